// File: rtl/hyper_cfg_sequencer.sv
// Programs and launches one HyperBus uDMA channel from a descriptor, then polls its CFG register until drained.
// Optional macro HYPER_SEQ_CLR_EN: write a clear command to the channel CFG register before the address/size writes.
module hyper_cfg_sequencer #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_DELAY     = 4,
  parameter int POLL_TIMEOUT   = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               req_ext_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_l2_addr_i,
  input  logic [TRANS_SIZE-1:0]     req_size_i,
  input  logic                      req_rx_i,
  input  logic [3:0]                req_mode_i,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  localparam int WCW = $clog2(POLL_DELAY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_SADDR, S_SIZE, S_EXTADDR, S_EXTCFG, S_LAUNCH, S_WAIT, S_POLL, S_DONE
  } state_t;

`ifdef HYPER_SEQ_CLR_EN
  localparam state_t FIRST_WR = S_CLR;
`else
  localparam state_t FIRST_WR = S_SADDR;
`endif

  state_t                    state_q, state_d;
  logic [31:0]               ext_q, ext_d;
  logic [L2_AWIDTH_NOAL-1:0] l2_q, l2_d;
  logic [TRANS_SIZE-1:0]     size_q, size_d;
  logic                      rx_q, rx_d;
  logic [3:0]                mode_q, mode_d;
  logic [WCW-1:0]            wait_q, wait_d;
  logic [PCW-1:0]            poll_q, poll_d;
  logic                      err_q, err_d;

  logic [4:0]     base;
  logic [PCW-1:0] poll_inc;
  logic           chan_idle;
  logic           unused_data;

  assign base      = rx_q ? 5'd0 : 5'd4;
  // Saturating increment so the counter can never wrap back below the timeout.
  assign poll_inc  = (poll_q == PCW'(POLL_TIMEOUT)) ? poll_q : poll_q + 1'b1;
  assign chan_idle = (cfg_data_i[5:4] == 2'b00);
  assign unused_data = ^{cfg_data_i[31:6], cfg_data_i[3:0]};

  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    l2_d        = l2_q;
    size_d      = size_q;
    rx_d        = rx_q;
    mode_d      = mode_q;
    wait_d      = wait_q;
    poll_d      = poll_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    cfg_valid_o = 1'b0;
    cfg_rwn_o   = 1'b0;
    cfg_addr_o  = 5'd0;
    cfg_data_o  = 32'd0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          ext_d   = req_ext_addr_i;
          l2_d    = req_l2_addr_i;
          size_d  = req_size_i;
          rx_d    = req_rx_i;
          mode_d  = req_mode_i;
          wait_d  = '0;
          poll_d  = '0;
          err_d   = 1'b0;
          state_d = (req_size_i == '0) ? S_DONE : FIRST_WR;
        end
      end
      S_CLR: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = base + 5'd2;
        cfg_data_o  = 32'h20;
        if (cfg_ready_i) state_d = S_SADDR;
      end
      S_SADDR: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = base;
        cfg_data_o  = 32'(l2_q);
        if (cfg_ready_i) state_d = S_SIZE;
      end
      S_SIZE: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = base + 5'd1;
        cfg_data_o  = 32'(size_q);
        if (cfg_ready_i) state_d = S_EXTADDR;
      end
      S_EXTADDR: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = 5'd8;
        cfg_data_o  = ext_q;
        if (cfg_ready_i) state_d = S_EXTCFG;
      end
      S_EXTCFG: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = 5'd9;
        cfg_data_o  = {28'h0, mode_q};
        if (cfg_ready_i) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = base + 5'd2;
        cfg_data_o  = 32'h10;
        if (cfg_ready_i) begin
          wait_d  = '0;
          state_d = (POLL_DELAY == 0) ? S_POLL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WCW'(POLL_DELAY - 1)) state_d = S_POLL;
        else                                wait_d  = wait_q + 1'b1;
      end
      S_POLL: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = base + 5'd2;
        if (cfg_ready_i) begin
          poll_d = poll_inc;
          // A drained channel wins even on the read that hits the timeout.
          if (chan_idle) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (poll_inc >= PCW'(POLL_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ext_q   <= '0;
      l2_q    <= '0;
      size_q  <= '0;
      rx_q    <= 1'b0;
      mode_q  <= '0;
      wait_q  <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      l2_q    <= l2_d;
      size_q  <= size_d;
      rx_q    <= rx_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_hyper_cfg_sequencer.sv
// Bench for hyper_cfg_sequencer: descriptor table, hand-written reset sequence and random descriptors vs a transaction-list model.
module tb_hyper_cfg_sequencer;
  localparam int PD = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_ext_addr_i = '0;
  logic [11:0] req_l2_addr_i = '0;
  logic [15:0] req_size_i = '0;
  logic        req_rx_i = 1'b0;
  logic [3:0]  req_mode_i = '0;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i = '0;
  logic        cfg_ready_i = 1'b0;
  logic        busy_o, done_o, err_o;

  hyper_cfg_sequencer #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_DELAY(PD), .POLL_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ext_addr_i(req_ext_addr_i), .req_l2_addr_i(req_l2_addr_i), .req_size_i(req_size_i),
    .req_rx_i(req_rx_i), .req_mode_i(req_mode_i), .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct {
    logic        rx;
    logic [31:0] ext;
    logic [11:0] l2;
    logic [15:0] size;
    logic [3:0]  mode;
    int          rdy_mode;   // 0 tied high, 1 one cycle in three, 2 random
    int          nbusy;      // status reads reporting busy before the channel drains
    logic [31:0] busy_dat;
    int          exp_reads;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        rwn;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

`ifdef HYPER_SEQ_CLR_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rcnt = 0;
  int rd_idx = 0;
  int stab_err = 0;
  int rdy_mode = 0;
  int cur_nbusy = 0;
  logic [31:0] cur_busy = 32'h10;
  logic [31:0] cur_clean = 32'h0;
  txn_t got[$];
  txn_t exp_q[$];

  logic        hold_pend = 1'b0, hs_pend = 1'b0;
  logic [4:0]  hold_addr, hs_addr;
  logic [31:0] hold_data, hs_data;
  logic        hold_rwn, hs_rwn;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Responder and protocol watcher; outputs are stable from here to the next rising edge.
  always @(negedge clk) begin
    if (hold_pend && !rst_i &&
        (!cfg_valid_o || cfg_addr_o !== hold_addr || cfg_data_o !== hold_data || cfg_rwn_o !== hold_rwn))
      stab_err++;
    if (err_o && !done_o) stab_err++;
    case (rdy_mode)
      0:       cfg_ready_i = 1'b1;
      1:       cfg_ready_i = (rcnt % 3 == 0);
      default: cfg_ready_i = 1'($urandom_range(0, 1));
    endcase
    rcnt++;
    if (rd_idx < cur_nbusy) cfg_data_i = (rd_idx == 0) ? cur_busy : 32'h10;
    else                    cfg_data_i = cur_clean;
    hold_pend = cfg_valid_o && !cfg_ready_i;
    hold_addr = cfg_addr_o; hold_data = cfg_data_o; hold_rwn = cfg_rwn_o;
    hs_pend   = cfg_valid_o && cfg_ready_i;
    hs_addr   = cfg_addr_o; hs_data = cfg_data_o; hs_rwn = cfg_rwn_o;
  end

  always @(posedge clk) begin
    if (hs_pend && !rst_i) begin
      got.push_back('{hs_rwn, hs_addr, hs_data, cyc});
      if (hs_rwn) rd_idx++;
    end
    cyc++;
  end

  // Reference: the ordered register accesses a descriptor must produce.
  function automatic int model_reads(input vec_t v);
    if (v.size == 0) return 0;
    return (v.nbusy + 1 < TO) ? v.nbusy + 1 : TO;
  endfunction

  function automatic void build_exp(input vec_t v);
    logic [4:0] b;
    int n;
    b = v.rx ? 5'd0 : 5'd4;
    exp_q.delete();
    if (v.size == 0) return;
`ifdef HYPER_SEQ_CLR_EN
    exp_q.push_back('{1'b0, b + 5'd2, 32'h20, 0});
`endif
    exp_q.push_back('{1'b0, b,        {20'h0, v.l2}, 0});
    exp_q.push_back('{1'b0, b + 5'd1, {16'h0, v.size}, 0});
    exp_q.push_back('{1'b0, 5'd8,     v.ext, 0});
    exp_q.push_back('{1'b0, 5'd9,     {28'h0, v.mode}, 0});
    exp_q.push_back('{1'b0, b + 5'd2, 32'h10, 0});
    n = model_reads(v);
    for (int j = 0; j < n; j++) exp_q.push_back('{1'b1, b + 5'd2, 32'h0, 0});
  endfunction

  task automatic start_vec(input vec_t v, output int acc);
    int n;
    rdy_mode  = v.rdy_mode;
    cur_nbusy = v.nbusy;
    cur_busy  = v.busy_dat;
    cur_clean = $urandom & ~32'h30;
    got.delete();
    rd_idx = 0;
    stab_err = 0;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_accept", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_ext_addr_i = v.ext; req_l2_addr_i = v.l2; req_size_i = v.size;
    req_rx_i = v.rx; req_mode_i = v.mode;
    acc = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_ext_addr_i = $urandom; req_l2_addr_i = 12'($urandom); req_size_i = 16'($urandom);
    req_rx_i = ~v.rx; req_mode_i = 4'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acc, n, dcyc, nrd;
    logic derr;
    start_vec(v, acc);
    chk({tag, " busy_after_accept"}, busy_o, 1);
    n = 0;
    while (!done_o && n < 3000) begin @(negedge clk); n++; end
    chk({tag, " done_seen"}, done_o, 1);
    dcyc = cyc;
    derr = err_o;
    chk({tag, " err"}, derr, v.exp_err);
    nrd = 0;
    foreach (got[i]) if (got[i].rwn) nrd++;
    chk({tag, " num_reads"}, nrd, v.exp_reads);
    build_exp(v);
    chk({tag, " num_txn"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s txn%0d rwn", tag, i), got[i].rwn, exp_q[i].rwn);
      chk($sformatf("%s txn%0d addr", tag, i), got[i].addr, exp_q[i].addr);
      chk($sformatf("%s txn%0d data", tag, i), got[i].data, exp_q[i].data);
      if (v.rdy_mode == 0)
        chk($sformatf("%s txn%0d cycle", tag, i), got[i].cyc - acc,
            (i < NW) ? i + 1 : i + 1 + PD);
    end
    if (got.size() > 0) chk({tag, " done_after_last_read"}, dcyc - got[got.size()-1].cyc, 1);
    else                chk({tag, " zero_size_done_latency"}, dcyc - acc, 1);
    chk({tag, " protocol_stable"}, stab_err, 0);
    @(negedge clk);
    chk({tag, " done_one_pulse"}, done_o, 0);
    chk({tag, " ready_again"}, req_ready_o, 1);
    chk({tag, " busy_low"}, busy_o, 0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_1000, 12'h120, 16'h0040, 4'd0, 0, 2,   32'h30, 3, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_1000, 12'h120, 16'h0040, 4'd0, 1, 2,   32'h30, 3, 1'b0};
    tbl[2] = '{1'b1, 32'hDEAD_BEEF, 12'hFFF, 16'hFFFF, 4'd2, 0, 100, 32'h10, 8, 1'b1};
    tbl[3] = '{1'b0, 32'h1234_5678, 12'h001, 16'h0000, 4'd1, 0, 0,   32'h10, 0, 1'b0};
    tbl[4] = '{1'b0, 32'hA5A5_A5A5, 12'h800, 16'h0001, 4'd1, 2, 7,   32'h20, 8, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0000, 12'h000, 16'h0001, 4'd0, 1, 8,   32'h30, 8, 1'b1};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF, 12'h555, 16'h8000, 4'd2, 0, 0,   32'h10, 1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst req_ready", req_ready_o, 1);
    chk("rst cfg_valid", cfg_valid_o, 0);
    chk("rst cfg_rwn", cfg_rwn_o, 0);
    chk("rst cfg_addr", cfg_addr_o, 0);
    chk("rst cfg_data", cfg_data_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst err", err_o, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while the external-address write is on the bus.
    begin
      int acc, n;
      start_vec(tbl[0], acc);
      n = 0;
      while (!(cfg_valid_o && cfg_addr_o == 5'd8) && n < 100) begin @(negedge clk); n++; end
      chk("rstmid reached_extaddr", cfg_addr_o, 8);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("rstmid cfg_valid", cfg_valid_o, 0);
      chk("rstmid busy", busy_o, 0);
      chk("rstmid req_ready", req_ready_o, 1);
      n = 0;
      for (int k = 0; k < 12; k++) begin
        if (done_o || cfg_valid_o) n++;
        @(negedge clk);
      end
      chk("rstmid no_done_no_traffic", n, 0);
      run_vec(tbl[1], "after_rst");
    end

    for (int i = 0; i < 20; i++) begin
      rv.rx       = 1'($urandom_range(0, 1));
      rv.ext      = $urandom;
      rv.l2       = 12'($urandom);
      rv.size     = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      rv.mode     = 4'($urandom_range(0, 2));
      rv.rdy_mode = $urandom_range(0, 2);
      rv.nbusy    = $urandom_range(0, 10);
      rv.busy_dat = ($urandom & ~32'h30) | (32'($urandom_range(1, 3)) << 4);
      rv.exp_reads = model_reads(rv);
      rv.exp_err   = (rv.size != 0) && (rv.nbusy >= TO);
      run_vec(rv, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
